// File: rtl/digital_lock_multi.sv
// Multi-digit keypad lock: IDLE/UNLOCKED/FAIL/LOCKOUT FSM with failed-try counting,
// timed lockout and optional auto-relock. Define LOCK_PROG_EN to make the code reprogrammable.
module digital_lock_multi #(
  parameter int DIGIT_W = 4,
  parameter int CODE_LEN = 4,
  parameter logic [DIGIT_W*CODE_LEN-1:0] DEFAULT_CODE = 16'hA5C3,
  parameter int MAX_TRIES = 3,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int RELOCK_CYCLES = 0,
  localparam int TW = $clog2(MAX_TRIES+1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               digit_valid,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               try_again,
  input  logic               relock,
`ifdef LOCK_PROG_EN
  input  logic               prog_en,
`endif
  output logic               led_output,
  output logic               fail,
  output logic               lockout,
  output logic [TW-1:0]      tries_left
);
  localparam int CW = DIGIT_W*CODE_LEN;
  localparam int NW = $clog2(CODE_LEN+1);
  localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam int RW = (RELOCK_CYCLES > 1) ? $clog2(RELOCK_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_UNLOCKED, S_FAIL, S_LOCKOUT} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   buf_q, buf_d, buf_nxt, code_cur;
  logic [NW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tries_d;
  logic [LW-1:0]   lk_q, lk_d;
  logic [RW-1:0]   rt_q, rt_d;
  logic            last, rt_expire;

  assign buf_nxt   = (buf_q << DIGIT_W) | CW'(digit);
  assign last      = (cnt_q == NW'(CODE_LEN-1));
  assign rt_expire = (RELOCK_CYCLES > 0) && (rt_q == '0);

`ifdef LOCK_PROG_EN
  logic [CW-1:0] code_q, code_d, sh_q, sh_d, sh_nxt;
  logic [NW-1:0] scnt_q, scnt_d;
  assign sh_nxt   = (sh_q << DIGIT_W) | CW'(digit);
  assign code_cur = code_q;
`else
  assign code_cur = DEFAULT_CODE;
`endif

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    tries_d = tries_left;
    lk_d    = lk_q;
    rt_d    = rt_q;
`ifdef LOCK_PROG_EN
    code_d  = code_q;
    sh_d    = sh_q;
    scnt_d  = scnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (try_again) begin
          buf_d = '0;
          cnt_d = '0;
        end else if (digit_valid) begin
          if (last) begin
            // Compare includes the digit being accepted on this edge.
            buf_d = '0;
            cnt_d = '0;
            if (buf_nxt == code_cur) begin
              state_d = S_UNLOCKED;
              tries_d = TW'(MAX_TRIES);
              rt_d    = RW'(RELOCK_CYCLES-1);
            end else if (tries_left > TW'(1)) begin
              state_d = S_FAIL;
              tries_d = tries_left - TW'(1);
            end else begin
              state_d = S_LOCKOUT;
              tries_d = '0;
              lk_d    = LW'(LOCKOUT_CYCLES-1);
            end
          end else begin
            buf_d = buf_nxt;
            cnt_d = cnt_q + NW'(1);
          end
        end
      end
      S_FAIL: begin
        if (try_again) begin
          state_d = S_IDLE;
          buf_d   = '0;
          cnt_d   = '0;
        end
      end
      S_LOCKOUT: begin
        if (lk_q == '0) begin
          state_d = S_IDLE;
          tries_d = TW'(MAX_TRIES);
        end else begin
          lk_d = lk_q - LW'(1);
        end
      end
      S_UNLOCKED: begin
        if (relock || rt_expire) state_d = S_IDLE;
        else if (RELOCK_CYCLES > 0) rt_d = rt_q - RW'(1);
`ifdef LOCK_PROG_EN
        if (state_d != S_UNLOCKED || !prog_en) begin
          sh_d   = '0;
          scnt_d = '0;
        end else if (digit_valid) begin
          if (scnt_q == NW'(CODE_LEN-1)) begin
            code_d = sh_nxt;
            sh_d   = '0;
            scnt_d = '0;
            rt_d   = RW'(RELOCK_CYCLES-1);
          end else begin
            sh_d   = sh_nxt;
            scnt_d = scnt_q + NW'(1);
          end
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      buf_q      <= '0;
      cnt_q      <= '0;
      lk_q       <= '0;
      rt_q       <= '0;
      tries_left <= TW'(MAX_TRIES);
      led_output <= 1'b0;
      fail       <= 1'b0;
      lockout    <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      lk_q       <= lk_d;
      rt_q       <= rt_d;
      tries_left <= tries_d;
      led_output <= (state_d == S_UNLOCKED);
      fail       <= (state_d == S_FAIL);
      lockout    <= (state_d == S_LOCKOUT);
    end
  end

`ifdef LOCK_PROG_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      code_q <= DEFAULT_CODE;
      sh_q   <= '0;
      scnt_q <= '0;
    end else begin
      code_q <= code_d;
      sh_q   <= sh_d;
      scnt_q <= scnt_d;
    end
  end
`endif
endmodule

// File: tb/tb_digital_lock_multi.sv
// Randomized bench for digital_lock_multi against an abstract queue-based lock model,
// with directed scenarios that pin the model to hand-computed values.
module tb_digital_lock_multi;
  localparam int          DW    = 4;
  localparam int          CL    = 4;
  localparam logic [15:0] CODE  = 16'hA5C3;
  localparam int          MAXT  = 3;
  localparam int          LOCKC = 16;
  localparam int          RELC  = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic digit_valid = 1'b0, try_again = 1'b0, relock = 1'b0;
  logic [DW-1:0] digit = '0;
`ifdef LOCK_PROG_EN
  logic prog_en = 1'b0;
`endif
  logic led_output, fail, lockout;
  logic [1:0] tries_left;

  digital_lock_multi #(.DIGIT_W(DW), .CODE_LEN(CL), .DEFAULT_CODE(CODE), .MAX_TRIES(MAXT),
                       .LOCKOUT_CYCLES(LOCKC), .RELOCK_CYCLES(RELC)) u_dut (
    .clk(clk), .reset(reset), .digit_valid(digit_valid), .digit(digit),
    .try_again(try_again), .relock(relock),
`ifdef LOCK_PROG_EN
    .prog_en(prog_en),
`endif
    .led_output(led_output), .fail(fail), .lockout(lockout), .tries_left(tries_left));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int lk_cnt = 0, led_cnt = 0;
  bit run = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Abstract model: mode 0 idle, 1 unlocked, 2 fail, 3 lockout; entry kept as a digit queue,
  // lockout/unlock durations as elapsed-cycle counts.
  logic [DW-1:0] code_dig[CL];
  logic [DW-1:0] q[$];
  int m_mode, m_tries, m_el;

  initial for (int i = 0; i < CL; i++) code_dig[i] = DW'(CODE >> ((CL-1-i)*DW));

  function automatic bit q_match();
    for (int i = 0; i < CL; i++) if (q[i] != code_dig[i]) return 0;
    return 1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = 0; m_tries = MAXT; m_el = 0; q.delete();
    end else begin
      case (m_mode)
        0: if (try_again) q.delete();
           else if (digit_valid) begin
             q.push_back(digit);
             if (q.size() == CL) begin
               if (q_match()) begin m_mode = 1; m_tries = MAXT; m_el = 0; end
               else if (m_tries > 1) begin m_mode = 2; m_tries--; end
               else begin m_mode = 3; m_tries = 0; m_el = 0; end
               q.delete();
             end
           end
        1: if (relock) m_mode = 0;
           else begin m_el++; if (m_el == RELC) m_mode = 0; end
        2: if (try_again) begin m_mode = 0; q.delete(); end
        default: begin m_el++; if (m_el == LOCKC) begin m_mode = 0; m_tries = MAXT; end end
      endcase
    end
  end

  always @(negedge clk) if (run) begin
    chk("led_output", int'(led_output), int'(m_mode == 1));
    chk("fail", int'(fail), int'(m_mode == 2));
    chk("lockout", int'(lockout), int'(m_mode == 3));
    chk("tries_left", int'(tries_left), m_tries);
  end

  task automatic cyc(input logic v, input logic [DW-1:0] dd, input logic t, input logic r);
    @(negedge clk);
    lk_cnt += int'(lockout);
    led_cnt += int'(led_output);
    digit_valid = v; digit = dd; try_again = t; relock = r;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, '0, 0, 0);
  endtask

  task automatic enter(input logic [15:0] w);
    for (int i = CL-1; i >= 0; i--) cyc(1, DW'(w >> (i*DW)), 0, 0);
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    digit_valid = 0; try_again = 0; relock = 0;
    #2 reset = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
  endtask

  initial begin
    #2 reset = 1'b0;
    #1 run = 1;
    repeat (2) @(negedge clk);
    chk("reset_tries", int'(tries_left), 3);
    chk("reset_led", int'(led_output), 0);
    #2 reset = 1'b1;

    // correct code unlocks on the edge taking the last digit
    enter(16'hA5C3);
    idle(1);
    chk("t1_led", int'(led_output), 1);
    chk("t1_tries", int'(tries_left), 3);
    cyc(0, '0, 0, 1);
    idle(1);
    chk("t5_relock", int'(led_output), 0);

    enter(16'h1234);
    idle(1);
    chk("t2_fail", int'(fail), 1);
    chk("t2_tries", int'(tries_left), 2);
    enter(16'hA5C3);
    idle(1);
    chk("t2_fail_hold", int'(fail), 1);
    cyc(0, '0, 1, 0);
    idle(1);
    chk("t2_fail_clr", int'(fail), 0);
    enter(16'hA5C3);
    led_cnt = 0;
    idle(12);
    chk("t2_tries_rst", int'(tries_left), 3);
    chk("t5_auto_relock_len", led_cnt, 8);

    // three failures in a row lock out
    enter(16'h1234); cyc(0, '0, 1, 0);
    enter(16'h9999); cyc(0, '0, 1, 0);
    enter(16'h0000);
    lk_cnt = 0;
    idle(1);
    chk("t3_tries0", int'(tries_left), 0);
    enter(16'hA5C3);
    idle(19);
    chk("t3_lockout_len", lk_cnt, 16);
    chk("t3_tries_back", int'(tries_left), 3);
    enter(16'hA5C3);
    idle(1);
    chk("t3_unlock", int'(led_output), 1);
    idle(10);

    // try_again beats a simultaneous digit
    cyc(1, 4'hA, 0, 0); cyc(1, 4'h5, 0, 0); cyc(1, 4'hC, 1, 0);
    enter(16'hC3A5);
    idle(1);
    chk("t4_fail", int'(fail), 1);
    chk("t4_no_unlock", int'(led_output), 0);
    cyc(0, '0, 1, 0);

    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 999));
      if (r < 3) rst_pulse();
      else if (r < 30) enter(16'hA5C3);
      else cyc(1'($urandom_range(0, 1)),
               ($urandom_range(0, 1) != 0) ? code_dig[$urandom_range(0, CL-1)] : DW'($urandom),
               ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
    end
    idle(2);
    run = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
